// File: rtl/snn_enc_pkg.sv
// Shared types and constants for the spike encoder.
// Build macro SPIKE_ENC_DITHER_EN selects a half-scale accumulator preload.
package snn_enc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } enc_state_t;

    localparam int MAG_W_DEF = 4;

`ifdef SPIKE_ENC_DITHER_EN
    localparam bit DITHER_EN = 1'b1;
`else
    localparam bit DITHER_EN = 1'b0;
`endif

    // Half-scale preload centres the spikes in the window without changing the count.
    function automatic int acc_preload(input int mag_w);
        return DITHER_EN ? (1 << (mag_w - 1)) : 0;
    endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// Handshake, magnitude and spike bundle between the upstream source and spike_encoder.
// Handshake: a pair transfers on a rising edge where in_valid && in_ready are both high.
interface spike_encoder_if #(parameter int MAG_W = snn_enc_pkg::MAG_W_DEF);
    import snn_enc_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [MAG_W-1:0] mag_1;
    logic             sgn_1;
    logic [MAG_W-1:0] mag_2;
    logic             sgn_2;
    logic             d_out_1;
    logic             s_out_1;
    logic             d_out_2;
    logic             s_out_2;
    logic             busy;
    logic             win_done;
    enc_state_t       state_dbg;

    modport master (
        output in_valid, mag_1, sgn_1, mag_2, sgn_2,
        input  in_ready, d_out_1, s_out_1, d_out_2, s_out_2, busy, win_done, state_dbg
    );

    modport slave (
        input  in_valid, mag_1, sgn_1, mag_2, sgn_2,
        output in_ready, d_out_1, s_out_1, d_out_2, s_out_2, busy, win_done, state_dbg
    );

endinterface

// File: rtl/spike_enc_lane.sv
// One rate-coding lane: captured magnitude/sign plus a phase accumulator whose carry is the spike.
module spike_enc_lane
    import snn_enc_pkg::*;
#(
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture,
    input  logic             step,
    input  logic [MAG_W-1:0] mag,
    input  logic             sgn,
    output logic             d_out,
    output logic             s_out
);

    localparam logic [MAG_W-1:0] PRELOAD = MAG_W'(acc_preload(MAG_W));

    logic [MAG_W-1:0] mag_q;
    logic [MAG_W-1:0] acc_q;
    logic             sgn_q;
    logic [MAG_W:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, mag_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
            sgn_q <= 1'b0;
            acc_q <= '0;
            d_out <= 1'b0;
            s_out <= 1'b0;
        end else if (capture) begin
            mag_q <= mag;
            sgn_q <= sgn;
            acc_q <= PRELOAD;
            d_out <= 1'b0;
            s_out <= 1'b0;
        end else if (step) begin
            // WIN steps of +mag wrap the accumulator exactly mag times.
            acc_q <= sum[MAG_W-1:0];
            d_out <= sum[MAG_W];
            s_out <= sum[MAG_W] & sgn_q;
        end else begin
            d_out <= 1'b0;
            s_out <= 1'b0;
        end
    end

endmodule

// File: rtl/spike_encoder.sv
// Two-lane rate-coded spike encoder: IDLE -> RUN (2^MAG_W steps) -> GAP (GAP_CYC cycles) -> IDLE.
// Build macro SPIKE_ENC_DITHER_EN enables the half-scale accumulator preload in both lanes.
module spike_encoder
    import snn_enc_pkg::*;
#(
    parameter int MAG_W   = MAG_W_DEF,
    parameter int GAP_CYC = 4
) (
    input logic             clk,
    input logic             rst_n,
    spike_encoder_if.slave  bus
);

    localparam logic [MAG_W-1:0] T_LAST = {MAG_W{1'b1}};
    localparam logic [7:0]       G_LAST = 8'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

    enc_state_t       state_q, state_d;
    logic [MAG_W-1:0] t_q;
    logic [7:0]       g_q;
    logic             capture, step, last_run;
    logic             ready_q, busy_q, win_done_q;
    logic             d1, s1, d2, s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        step     = 1'b0;
        last_run = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && ready_q) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (t_q == T_LAST) begin
                    last_run = 1'b1;
                    state_d  = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (g_q == G_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Flag outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q        <= '0;
            g_q        <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            win_done_q <= 1'b0;
        end else begin
            if (capture)   t_q <= '0;
            else if (step) t_q <= t_q + 1'b1;
            g_q        <= (state_q == GAP) ? g_q + 8'd1 : 8'd0;
            ready_q    <= (state_d == IDLE);
            busy_q     <= (state_d != IDLE);
            win_done_q <= last_run;
        end
    end

    spike_enc_lane #(.MAG_W(MAG_W)) u_lane_1 (
        .clk(clk), .rst_n(rst_n), .capture(capture), .step(step),
        .mag(bus.mag_1), .sgn(bus.sgn_1), .d_out(d1), .s_out(s1)
    );

    spike_enc_lane #(.MAG_W(MAG_W)) u_lane_2 (
        .clk(clk), .rst_n(rst_n), .capture(capture), .step(step),
        .mag(bus.mag_2), .sgn(bus.sgn_2), .d_out(d2), .s_out(s2)
    );

    assign bus.in_ready  = ready_q;
    assign bus.busy      = busy_q;
    assign bus.win_done  = win_done_q;
    assign bus.state_dbg = state_q;
    assign bus.d_out_1   = d1;
    assign bus.s_out_1   = s1;
    assign bus.d_out_2   = d2;
    assign bus.s_out_2   = s2;

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: scoreboard of captured pairs checked at each window end.
module tb_spike_encoder;
    import snn_enc_pkg::*;

    localparam int MAG_W   = 4;
    localparam int WIN     = 16;
    localparam int GAP_CYC = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spike_encoder_if #(.MAG_W(MAG_W)) bus ();
    spike_encoder_if #(.MAG_W(MAG_W)) bus0 ();

    spike_encoder #(.MAG_W(MAG_W), .GAP_CYC(GAP_CYC)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    spike_encoder #(.MAG_W(MAG_W), .GAP_CYC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected spike-step mask, derived from the spike placement rule.
    function automatic logic [15:0] exp_mask(input int m);
        logic [15:0] r;
        r = '0;
`ifdef SPIKE_ENC_DITHER_EN
        for (int n = 1; n <= WIN; n++)
            if (((8 + n * m) / WIN) != ((8 + (n - 1) * m) / WIN)) r[n-1] = 1'b1;
`else
        for (int k = 1; k <= m; k++)
            r[((k * WIN + m - 1) / m) - 1] = 1'b1;
`endif
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    logic [9:0]  exp_q[$];
    logic        run_active = 1'b0;
    logic        cap_flag = 1'b0;
    int          since_done = -1;
    int          step = 0;
    int          busy_cycles = 0;
    logic [15:0] obs_d1, obs_s1, obs_d2, obs_s2;

    task automatic score_window();
        logic [9:0]  e;
        logic [15:0] m1, m2;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
            e  = exp_q.pop_front();
            m1 = exp_mask(int'(e[9:6]));
            m2 = exp_mask(int'(e[4:1]));
            check_eq("d1_spikes", 32'(obs_d1), 32'(m1));
            check_eq("s1_spikes", 32'(obs_s1), e[5] ? 32'(m1) : 32'd0);
            check_eq("d2_spikes", 32'(obs_d2), 32'(m2));
            check_eq("s2_spikes", 32'(obs_s2), e[0] ? 32'(m2) : 32'd0);
            check_eq("d1_count", 32'($countones(obs_d1)), 32'(e[9:6]));
            check_eq("d2_count", 32'($countones(obs_d2)), 32'(e[4:1]));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            run_active = 1'b0;
            cap_flag   = 1'b0;
            since_done = -1;
        end else begin
            if (cap_flag) begin
                run_active = 1'b1;
                step = 0;
                busy_cycles = 1;
                obs_d1 = '0; obs_s1 = '0; obs_d2 = '0; obs_s2 = '0;
                check_eq("run_flags", 32'({bus.busy, bus.in_ready}), 32'b10);
            end else if (run_active) begin
                step++;
                busy_cycles++;
                obs_d1[step-1] = bus.d_out_1;
                obs_s1[step-1] = bus.s_out_1;
                obs_d2[step-1] = bus.d_out_2;
                obs_s2[step-1] = bus.s_out_2;
                check_eq("run_flags", 32'({bus.busy, bus.in_ready}), 32'b10);
                if (step == WIN) begin
                    check_eq("win_done_last", 32'(bus.win_done), 32'd1);
                    score_window();
                    run_active = 1'b0;
                    since_done = 0;
                end else begin
                    check_eq("win_done_early", 32'(bus.win_done), 32'd0);
                end
            end else if (since_done >= 0) begin
                since_done++;
                if (since_done < GAP_CYC) begin
                    busy_cycles++;
                    check_eq("gap_state", 32'({bus.busy, bus.in_ready, bus.d_out_1, bus.d_out_2,
                             bus.s_out_1, bus.s_out_2, bus.win_done}), 32'b1000000);
                end else begin
                    check_eq("gap_release", 32'({bus.busy, bus.in_ready}), 32'b01);
                    check_eq("busy_len", 32'(busy_cycles), 32'(WIN + GAP_CYC));
                    since_done = -1;
                end
            end else begin
                check_eq("idle_quiet", 32'({bus.busy, bus.d_out_1, bus.s_out_1, bus.d_out_2,
                         bus.s_out_2, bus.win_done}), 32'd0);
            end
            cap_flag = bus.in_valid && bus.in_ready;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [3:0] m1, input logic s1, input logic [3:0] m2,
                        input logic s2, output int cap_cyc);
        bit done;
        done = 1'b0;
        cap_cyc = -1;
        bus.mag_1 = m1; bus.sgn_1 = s1; bus.mag_2 = m2; bus.sgn_2 = s2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #2;
                exp_q.push_back({m1, s1, m2, s2});
                cap_cyc = cyc;
                done = 1'b1;
            end
        end
        if (!done) check_eq("send_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic drop_valid();
        bus.in_valid = 1'b0;
        bus.mag_1 = 4'($urandom_range(0, 15));
        bus.mag_2 = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (i < 80 && (run_active || since_done >= 0 || !bus.in_ready)) begin
            @(negedge clk);
            #1;
            i++;
        end
        check_eq("idle_reached", 32'({bus.in_ready, bus.busy}), 32'b10);
        @(posedge clk);
        #2;
    endtask

    task automatic one_pair(input logic [3:0] m1, input logic s1, input logic [3:0] m2, input logic s2);
        int c;
        send(m1, s1, m2, s2, c);
        drop_valid();
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    int caps[3];
    int c_tmp, cap0, cap1, wd, cnt1, cnt2;

    initial begin
        bus.in_valid = 1'b0; bus.mag_1 = '0; bus.sgn_1 = 1'b0; bus.mag_2 = '0; bus.sgn_2 = 1'b0;
        bus0.in_valid = 1'b0; bus0.mag_1 = '0; bus0.sgn_1 = 1'b0; bus0.mag_2 = '0; bus0.sgn_2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", 32'({bus.d_out_1, bus.s_out_1, bus.d_out_2, bus.s_out_2,
                 bus.busy, bus.win_done}), 32'd0);
        check_eq("reset_state", 32'(bus.state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #2;

        one_pair(4'd5, 1'b0, 4'd15, 1'b1);
        one_pair(4'd0, 1'b0, 4'd0, 1'b0);
        one_pair(4'd1, 1'b0, 4'd1, 1'b1);

        // Valid held high across three windows.
        send(4'd2, 1'b1, 4'd9, 1'b0, caps[0]);
        send(4'd7, 1'b0, 4'd3, 1'b1, caps[1]);
        send(4'd12, 1'b1, 4'd1, 1'b0, caps[2]);
        drop_valid();
        check_eq("held_gap_a", 32'(caps[1] - caps[0]), 32'(WIN + GAP_CYC + 1));
        check_eq("held_gap_b", 32'(caps[2] - caps[1]), 32'(WIN + GAP_CYC + 1));
        wait_idle();

        // Reset in the middle of a window.
        send(4'd9, 1'b1, 4'd15, 1'b1, c_tmp);
        drop_valid();
        repeat (7) @(posedge clk);
        check_eq("pre_rst_spike", 32'(bus.d_out_2), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_outs", 32'({bus.d_out_1, bus.s_out_1, bus.d_out_2, bus.s_out_2,
                 bus.win_done, bus.busy}), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #2;
        one_pair(4'd9, 1'b1, 4'd6, 1'b0);

        for (int i = 0; i < 4; i++)
            one_pair(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));

        // Zero-gap instance: RUN returns straight to IDLE.
        bus0.mag_1 = 4'd3; bus0.sgn_1 = 1'b0; bus0.mag_2 = 4'd7; bus0.sgn_2 = 1'b1;
        bus0.in_valid = 1'b1;
        cap0 = -1; cap1 = -1; wd = -1; cnt1 = 0; cnt2 = 0;
        for (int i = 0; i < 10 && cap0 < 0; i++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                @(posedge clk);
                #2;
                cap0 = cyc;
            end
        end
        for (int i = 0; i < 40 && wd < 0; i++) begin
            @(negedge clk);
            cnt1 += int'(bus0.d_out_1);
            cnt2 += int'(bus0.d_out_2);
            if (bus0.win_done) begin
                wd = cyc;
                check_eq("g0_flags", 32'({bus0.in_ready, bus0.busy}), 32'b10);
                if (bus0.in_ready) begin
                    @(posedge clk);
                    #2;
                    cap1 = cyc;
                end
            end
        end
        bus0.in_valid = 1'b0;
        check_eq("g0_win_pos", 32'(wd - cap0), 32'(WIN));
        check_eq("g0_count_1", 32'(cnt1), 32'd3);
        check_eq("g0_count_2", 32'(cnt2), 32'd7);
        check_eq("g0_next_cap", 32'(cap1 - wd), 32'd1);
        check_eq("g0_spacing", 32'(cap1 - cap0), 32'(WIN + 1));

        repeat (5) @(posedge clk);
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
